// File: rtl/arbitro_entradas.sv
// Five-port input buffering with round-robin arbitration onto one registered
// 17-bit packet output (bit 16 valid, [15:12] dest x, [11:8] dest y, [7:0] payload).
module arbitro_entradas #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [16:0] cima_in,
  input  logic [16:0] baixo_in,
  input  logic [16:0] esquerda_in,
  input  logic [16:0] direita_in,
  input  logic [16:0] core_in,
  output logic [4:0]  in_ready,
  output logic [16:0] pkt_out,
  input  logic        out_ready,
  output logic [4:0]  grant,
  output logic [15:0] pkt_count
);

  localparam int NP = 5;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {EMPTY, LOADED} out_state_t;

  logic [16:0]   in_word [NP];
  logic [16:0]   mem     [NP][DEPTH];
  logic [AW-1:0] wr_ptr  [NP];
  logic [AW-1:0] rd_ptr  [NP];
  logic [CW-1:0] count   [NP];
  logic [NP-1:0] push;
  logic [NP-1:0] pop;
  logic [NP-1:0] nonempty;

  out_state_t    state;
  logic [2:0]    ptr;
  logic          can_load;
  logic          win_valid;
  logic [2:0]    win_idx;
  logic [2:0]    next_ptr;
  logic [16:0]   win_word;
  logic [3:0]    cand;

  assign in_word[0] = cima_in;
  assign in_word[1] = baixo_in;
  assign in_word[2] = esquerda_in;
  assign in_word[3] = direita_in;
  assign in_word[4] = core_in;

  // Acceptance looks only at occupancy, so a full FIFO refuses even while it pops.
  always_comb begin
    for (int i = 0; i < NP; i++) begin
      in_ready[i] = rst && (count[i] != FULL);
      nonempty[i] = (count[i] != '0);
      push[i]     = in_word[i][16] && in_ready[i];
    end
  end

  // Scan from the farthest offset back to ptr so the nearest non-empty port wins.
  always_comb begin
    can_load  = (state == EMPTY) || out_ready;
    win_valid = 1'b0;
    win_idx   = '0;
    win_word  = '0;
    cand      = '0;
    for (int k = NP - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + 4'(k);
      if (cand >= 4'd5) cand = cand - 4'd5;
      if (nonempty[cand[2:0]]) begin
        win_valid = 1'b1;
        win_idx   = cand[2:0];
        win_word  = mem[cand[2:0]][rd_ptr[cand[2:0]]];
      end
    end
    next_ptr = (win_idx == 3'd4) ? 3'd0 : win_idx + 3'd1;
    pop      = '0;
    if (can_load && win_valid) pop[win_idx] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational logic above.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NP; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NP; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
        if (push[i] && !pop[i])      count[i] <= count[i] + CW'(1);
        else if (!push[i] && pop[i]) count[i] <= count[i] - CW'(1);
      end
    end
  end

  // NOTE: storage is not reset; emptiness is tracked by count, and leaving
  // the array reset-free lets it map onto plain RAM/flops without reset fan-out.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NP; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= in_word[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= EMPTY;
      pkt_out   <= '0;
      grant     <= '0;
      ptr       <= '0;
      pkt_count <= '0;
    end else begin
      if (state == LOADED && out_ready) pkt_count <= pkt_count + 16'd1;
      if (can_load) begin
        if (win_valid) begin
          state   <= LOADED;
          pkt_out <= win_word;
          grant   <= 5'b00001 << win_idx;
          ptr     <= next_ptr;
        end else begin
          state   <= EMPTY;
          pkt_out <= '0;
          grant   <= '0;
        end
      end
    end
  end

endmodule
